mips_multicycle_control: RTL and testbench

//  Main control FSM for the multi-cycle MIPS datapath. One memory, one ALU and the register file are shared across

---
 rtl/mips_multicycle_control.sv | 203 ++++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath; steers every mux select and write strobe from the current state.
// Outputs are decoded from state within the cycle; memory states stall on mem_ready and trap after MEM_TIMEOUT cycles.
module mips_multicycle_control #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] MemtoReg,
    output logic [1:0] RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       trap
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        I_EXEC    = 4'd10,
        I_WB      = 4'd11,
        JAL       = 4'd12,
        JR        = 4'd13,
        ERROR     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

    state_t     st;
    logic [7:0] wait_cnt;
    logic       timeout;

    // The wait counter holds the number of stalled cycles already spent, so the
    // MEM_TIMEOUT-th stalled cycle is the last chance for mem_ready to win.
    assign timeout = (wait_cnt == WAIT_LIMIT);
    assign state   = st;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st       <= FETCH;
            wait_cnt <= '0;
            trap     <= 1'b0;
        end else begin
            wait_cnt <= '0;
            case (st)
                FETCH, MEM_READ, MEM_WRITE: begin
                    if (mem_ready) begin
                        case (st)
                            FETCH:    st <= DECODE;
                            MEM_READ: st <= MEM_WB;
                            default:  st <= FETCH;
                        endcase
                    end else if (timeout) begin
                        st   <= ERROR;
                        trap <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: st <= MEM_ADDR;
                        OP_RTYPE:     st <= (funct == FN_JR) ? JR : R_EXEC;
                        OP_BEQ:       st <= BRANCH;
                        OP_J:         st <= JUMP;
                        OP_JAL:       st <= JAL;
                        OP_ADDI:      st <= I_EXEC;
                        default: begin
                            st   <= ERROR;
                            trap <= 1'b1;
                        end
                    endcase
                end
                MEM_ADDR: begin
                    if (opcode == OP_LW) begin
                        st <= MEM_READ;
                    end else if (opcode == OP_SW) begin
                        st <= MEM_WRITE;
                    end else begin
                        st   <= ERROR;
                        trap <= 1'b1;
                    end
                end
                R_EXEC: st <= R_WB;
                I_EXEC: st <= I_WB;
                MEM_WB, R_WB, I_WB, BRANCH, JUMP, JAL, JR: st <= FETCH;
                default: begin
                    st   <= ERROR;
                    trap <= 1'b1;
                end
            endcase
        end
    end

    // Everything is forced to zero while reset is held so an aborted instruction commits nothing.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 2'd0;
        RegDst      = 2'd0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'd0;
        ALUOp       = 2'd0;
        PCSource    = 2'd0;
        if (rst_n) begin
            case (st)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'd1;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                DECODE: ALUSrcB = 2'd3;
                MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'd2;
                end
                MEM_READ: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                MEM_WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 2'd1;
                end
                MEM_WRITE: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                R_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'd2;
                end
                R_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = 2'd1;
                end
                I_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'd2;
                    ALUOp   = 2'd3;
                end
                I_WB: RegWrite = 1'b1;
                BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'd1;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'd1;
                end
                JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'd2;
                end
                JAL: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'd2;
                    RegWrite = 1'b1;
                    RegDst   = 2'd2;
                    MemtoReg = 2'd2;
                end
                JR: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'd3;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: each driven cycle pushes the expected state/controls/trap,
// and a negedge monitor pops and compares against the DUT.
module tb_mips_multicycle_control;

    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       irw;
        logic [1:0] m2r;
        logic [1:0] rdst;
        logic       rw;
        logic       asa;
        logic [1:0] asb;
        logic [1:0] aop;
        logic [1:0] pcs;
    } ctrl_t;

    typedef struct packed {
        logic [3:0] st;
        ctrl_t      c;
        logic       tr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       alu_zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, trap;
    logic [1:0] MemtoReg, RegDst, ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;
    int cyc_no = 0;
    exp_t sb[$];

    mips_multicycle_control #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCSource(PCSource), .state(state), .trap(trap)
    );

    always #5 clk = ~clk;

    function automatic ctrl_t mk(input logic pcw, input logic pcwc, input logic iord, input logic mr,
                                 input logic mw, input logic irw, input logic [1:0] m2r,
                                 input logic [1:0] rdst, input logic rw, input logic asa,
                                 input logic [1:0] asb, input logic [1:0] aop, input logic [1:0] pcs);
        ctrl_t c;
        c = '{pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, pcs};
        return c;
    endfunction

    ctrl_t ZERO, F_RDY, F_WAIT, DEC, MADDR, MRD, MWB, MWR, REX, RWB, IEX, IWB, BR, JMP, JL, JRC;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h expected %h", tag, cyc_no, got, exp);
        end
    endtask

    ctrl_t dut_c;
    assign dut_c = '{PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                     RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check_eq("state", 32'(state), 32'(e.st));
            check_eq("ctrl", 32'(dut_c), 32'(e.c));
            check_eq("trap", 32'(trap), 32'(e.tr));
            cyc_no++;
        end
    end

    // One clock cycle: drive inputs just after the edge, queue what the outputs must be this cycle.
    task automatic cyc(input logic rst, input logic rdy, input logic [3:0] st, input ctrl_t c, input logic tr);
        exp_t e;
        rst_n     = rst;
        mem_ready = rdy;
        e = '{st, c, tr};
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
        cyc(1, 1, 4'd0, F_RDY, 0);
        cyc(1, 1, 4'd1, DEC, 0);
    endtask

    initial begin
        ZERO   = '0;
        F_RDY  = mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        F_WAIT = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        DEC    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        MADDR  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
        MRD    = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        MWB    = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        MWR    = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        REX    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0);
        RWB    = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        IEX    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0);
        IWB    = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        BR     = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
        JMP    = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        JL     = mk(1, 0, 0, 0, 0, 0, 2, 2, 1, 0, 0, 0, 2);
        JRC    = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);

        @(posedge clk);
        @(posedge clk);
        #1;
        cyc(0, 0, 4'd0, ZERO, 0);

        // lw, no wait states
        fetch_decode(6'h23, 6'h00);
        cyc(1, 1, 4'd2, MADDR, 0);
        cyc(1, 1, 4'd3, MRD, 0);
        cyc(1, 1, 4'd4, MWB, 0);

        // R-type add then jr
        fetch_decode(6'h00, 6'h20);
        cyc(1, 1, 4'd6, REX, 0);
        cyc(1, 1, 4'd7, RWB, 0);
        fetch_decode(6'h00, 6'h08);
        cyc(1, 1, 4'd13, JRC, 0);

        // beq taken and not taken: controls do not depend on alu_zero
        alu_zero = 1'b1;
        fetch_decode(6'h04, 6'h00);
        cyc(1, 1, 4'd8, BR, 0);
        alu_zero = 1'b0;
        fetch_decode(6'h04, 6'h00);
        cyc(1, 0, 4'd8, BR, 0);

        // j, jal, addi
        fetch_decode(6'h02, 6'h00);
        cyc(1, 0, 4'd9, JMP, 0);
        fetch_decode(6'h03, 6'h00);
        cyc(1, 1, 4'd12, JL, 0);
        fetch_decode(6'h08, 6'h00);
        cyc(1, 0, 4'd10, IEX, 0);
        cyc(1, 1, 4'd11, IWB, 0);

        // sw with five wait cycles
        fetch_decode(6'h2B, 6'h00);
        cyc(1, 0, 4'd2, MADDR, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 4'd5, MWR, 0);
        cyc(1, 1, 4'd5, MWR, 0);

        // fetch completes on the 16th cycle: completion beats the limit
        opcode = 6'h23;
        for (int i = 0; i < 15; i++) cyc(1, 0, 4'd0, F_WAIT, 0);
        cyc(1, 1, 4'd0, F_RDY, 0);
        cyc(1, 1, 4'd1, DEC, 0);
        cyc(1, 1, 4'd2, MADDR, 0);
        // reset in MEM_READ aborts the load with no register write
        cyc(0, 1, 4'd3, ZERO, 0);
        cyc(1, 1, 4'd0, F_RDY, 0);
        cyc(1, 1, 4'd1, DEC, 0);
        cyc(1, 1, 4'd2, MADDR, 0);
        cyc(1, 1, 4'd3, MRD, 0);
        cyc(1, 1, 4'd4, MWB, 0);

        // illegal opcode traps and stays trapped
        fetch_decode(6'h3F, 6'h00);
        cyc(1, 1, 4'd15, ZERO, 1);
        cyc(1, 1, 4'd15, ZERO, 1);
        cyc(0, 0, 4'd15, ZERO, 1);
        cyc(1, 0, 4'd0, F_WAIT, 0);

        // fetch timeout: 16 stalled cycles, the one above counts as the first
        for (int i = 0; i < 15; i++) cyc(1, 0, 4'd0, F_WAIT, 0);
        cyc(1, 0, 4'd15, ZERO, 1);
        cyc(1, 1, 4'd15, ZERO, 1);
        cyc(0, 1, 4'd15, ZERO, 1);
        cyc(1, 0, 4'd0, F_WAIT, 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain scoreboard left %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
